acc_traffic_driver: RTL

//  Drives the other end of an accelerator's decoupled valid/ready data path: master on the

---
 rtl/acc_traffic_driver.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_traffic_driver.sv
// Traffic driver for an accelerator slot: per batch, sends ser_ratio words on the tx side,
// then accepts des_ratio words back on the rx side, tracking counts, latency and errors.
module acc_traffic_driver #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter bit          CHECK_ECHO = 1'b1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_batches,
  input  logic [15:0]           ser_ratio,
  input  logic [15:0]           des_ratio,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  output logic [31:0]           tx_count,
  output logic [31:0]           rx_count,
  output logic [15:0]           max_latency
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   nb_q, nb_d;
  logic [CW-1:0]   ser_q, ser_d;
  logic [CW-1:0]   des_q, des_d;
  logic [CW-1:0]   batch_q, batch_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            lat_armed_q, lat_armed_d;
  logic [DW-1:0]   last_tx_q, last_tx_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            rx_ready_q, rx_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      error_q, error_d;
  logic [31:0]     tx_count_q, tx_count_d;
  logic [31:0]     rx_count_q, rx_count_d;
  logic [LW-1:0]   max_lat_q, max_lat_d;

  logic            tx_hs;
  logic            rx_hs;
  logic            idle_expired;
  logic            batch_end;

  assign tx_hs        = tx_valid_q & tx_ready;
  assign rx_hs        = rx_valid & rx_ready_q;
  assign idle_expired = (idle_q == TW'(TIMEOUT - 1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    nb_d        = nb_q;
    ser_d       = ser_q;
    des_d       = des_q;
    batch_d     = batch_q;
    word_cnt_d  = word_cnt_q;
    idle_d      = idle_q;
    lat_d       = lat_q;
    lat_armed_d = lat_armed_q;
    last_tx_d   = last_tx_q;
    tx_data_d   = tx_data_q;
    error_d     = error_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    max_lat_d   = max_lat_q;
    batch_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nb_d        = num_batches;
          ser_d       = ser_ratio;
          des_d       = des_ratio;
          tx_data_d   = seed;
          last_tx_d   = seed - DW'(1);
          batch_d     = '0;
          word_cnt_d  = '0;
          idle_d      = '0;
          lat_d       = '0;
          lat_armed_d = 1'b0;
          error_d     = '0;
          tx_count_d  = '0;
          rx_count_d  = '0;
          max_lat_d   = '0;
          state_d     = (num_batches == '0) ? S_DONE : S_SEND;
        end
      end

      S_SEND: begin
        idle_d = idle_q + TW'(1);
        if (ser_q == '0) begin
          word_cnt_d  = '0;
          idle_d      = '0;
          lat_armed_d = 1'b0;
          state_d     = S_RECV;
        end else if (tx_hs) begin
          tx_count_d = tx_count_q + 32'd1;
          tx_data_d  = tx_data_q + DW'(1);
          last_tx_d  = tx_data_q;
          idle_d     = '0;
          word_cnt_d = word_cnt_q + CW'(1);
          if (word_cnt_q + CW'(1) == ser_q) begin
            word_cnt_d  = '0;
            lat_d       = '0;
            lat_armed_d = (des_q != '0);
            state_d     = S_RECV;
          end
        end else if (idle_expired) begin
          error_d[1] = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_RECV: begin
        idle_d = idle_q + TW'(1);
        if (des_q == '0) begin
          batch_end = 1'b1;
        end else if (rx_hs) begin
          rx_count_d = rx_count_q + 32'd1;
          idle_d     = '0;
          if (CHECK_ECHO && (rx_data != last_tx_q)) begin
            error_d[0] = 1'b1;
          end
          if (lat_armed_q) begin
            lat_armed_d = 1'b0;
            if (lat_q > max_lat_q) begin
              max_lat_d = lat_q;
            end
          end
          word_cnt_d = word_cnt_q + CW'(1);
          if (word_cnt_q + CW'(1) == des_q) begin
            batch_end = 1'b1;
          end
        end else begin
          if (lat_armed_q && (lat_q != {LW{1'b1}})) begin
            lat_d = lat_q + LW'(1);
          end
          if (idle_expired) begin
            error_d[1] = 1'b1;
            state_d    = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Batch completion: next batch or end of run.
    if (batch_end) begin
      batch_d    = batch_q + CW'(1);
      word_cnt_d = '0;
      idle_d     = '0;
      state_d    = (batch_q + CW'(1) == nb_q) ? S_DONE : S_SEND;
    end

    tx_valid_d = (state_d == S_SEND) && (ser_d != '0);
    rx_ready_d = (state_d == S_RECV) && (des_d != '0);
    busy_d     = (state_d == S_SEND) || (state_d == S_RECV);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nb_q        <= '0;
      ser_q       <= '0;
      des_q       <= '0;
      batch_q     <= '0;
      word_cnt_q  <= '0;
      idle_q      <= '0;
      lat_q       <= '0;
      lat_armed_q <= 1'b0;
      last_tx_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      max_lat_q   <= '0;
    end else begin
      state_q     <= state_d;
      nb_q        <= nb_d;
      ser_q       <= ser_d;
      des_q       <= des_d;
      batch_q     <= batch_d;
      word_cnt_q  <= word_cnt_d;
      idle_q      <= idle_d;
      lat_q       <= lat_d;
      lat_armed_q <= lat_armed_d;
      last_tx_q   <= last_tx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      max_lat_q   <= max_lat_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign rx_ready    = rx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign tx_count    = tx_count_q;
  assign rx_count    = rx_count_q;
  assign max_latency = max_lat_q;

endmodule
